stage_pipe_reg: RTL and testbench
=================================

# stage_pipe_reg

Parametrised pipeline stage register, the successor to the fixed per-stage latch registers between decode and execute. It carries a DATA_W payload (operands, immediate) and a CTRL_W control field (write-enable, write-select, ALU op, data-source) with a valid/ready handshake. It also provides synchronous flush for bubble insertion and an optional 2-entry skid buffer for full throughput with a registered ready. It sits between any two pipeline stages, replacing hard-wired S1/S2/S3 registers.

## Interface
- DATA_W, 64, payload width (e.g. two 32-bit read operands)
- CTRL_W, 25, control field width; forced to zero whenever the stage holds a bubble
- CNT_W, 16, stall counter width
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock, asynchronous, active-low
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control field
- flush  input  1  synchronous kill of all held and incoming beats
- out_valid  output  1  stage holds a valid beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_W  held payload
- out_ctrl  output  CTRL_W  held control; 0 when out_valid=0
- cnt_clr  input  1  synchronous clear of stall_cnt
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles

## Operation
- Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready.
- Data is never dropped, duplicated or reordered, except by flush.
- State machine (skid build):
  - EMPTY (main invalid): accept -> BUSY, main <= in.
  - BUSY (main valid, skid empty):
    - accept & fire -> BUSY, main <= in.
    - accept & !fire -> FULL, skid <= in.
    - !accept & fire -> EMPTY.
  - FULL (both valid): no accept possible. Fire -> BUSY, main <= skid.
- Without the skid buffer, only EMPTY and BUSY exist; see Configuration.
- Flush takes priority over everything in its cycle:
  - Next state is EMPTY and both valid bits clear.
  - Main and skid ctrl registers are cleared.
  - A same-cycle accept is discarded.
  - A same-cycle fire still counts as delivered downstream.
- out_ctrl is cleared whenever main becomes invalid, so bubbles carry write-enable = 0.
- out_data holds its last value in EMPTY and is not cleared except by reset.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr sets it to 0 and takes priority over increment.
  - Flush does not affect it.

## Timing
- Reset (rst=0, asynchronous) values:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - Skid registers cleared.
  - in_ready=1 in the skid build; in the non-skid build it is combinational.
- Latency is 1 cycle: a beat accepted at edge N is on out_* after edge N, in both builds.
- Throughput is 1 beat per cycle while out_ready=1.
- in_ready:
  - Skid build: a registered signal, = !skid_valid. It drops the cycle after an accept with !fire in BUSY. It is never combinationally dependent on out_ready.
  - In FULL it is 0 until the cycle after a fire.
- Reset deassertion is synchronised externally; the block takes no action on the release edge beyond leaving reset.
- Reset asserted mid-operation: all held beats are lost immediately, with no wait for clk.

## Configuration
- STAGE_PIPE_REG_SKID_EN defined: skid buffer and FULL state compiled in; in_ready is registered.
- Undefined:
  - No skid registers; in_ready = !out_valid | out_ready (combinational).
  - Accept while BUSY requires fire in the same cycle.
  - Flush, stall_cnt and latency behaviour are identical to the skid build.

## Test plan
- Reset and streaming:
  - Stimulus: hold rst=0, release, stream in_data 1,2,3 with out_ready=1.
  - Required: out_valid=0 and out_ctrl=0 during reset; outputs 1,2,3 on the 3 cycles following each accept; stall_cnt=0.
- Back-pressure (skid build):
  - Stimulus: stream 0xA, 0xB, 0xC with out_ready=0.
  - Required: 0xA held; 0xB captured in skid; in_ready=0 next cycle, so 0xC stalls upstream.
  - Then raise out_ready: outputs 0xA, 0xB, 0xC in order with no gaps; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush in FULL with simultaneous in_valid:
  - Required: next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears at the output.
- Stall counter saturation and clear:
  - Stimulus: CNT_W=4, out_ready=0 for 20 cycles.
  - Required: stall_cnt=15 and holds; cnt_clr pulse gives stall_cnt=0; cnt_clr and a stall in the same cycle gives 0.
- Non-skid build:
  - Stimulus: out_ready toggles 1,0,1.
  - Required: in_ready follows !out_valid | out_ready in the same cycle; no beat lost or duplicated across 100 random valid/ready cycles, checked against a scoreboard.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst between clock edges while in FULL.
  - Required: out_valid=0 and stall_cnt=0 immediately, without a clk edge.

Source files
------------

// File: rtl/stage_pipe_reg.sv
`default_nettype none
// ============================================================================
//  stage_pipe_reg
//  Valid/ready pipeline stage register with flush and a saturating stall
//  counter. Define STAGE_PIPE_REG_SKID_EN for the 2-entry skid build.
//  Revision: 1.0
// ============================================================================
module stage_pipe_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 25,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                w_accept;
   logic                w_fire;
   logic                w_ld_main_in;
   logic                w_clr_main_ctrl;
`ifdef STAGE_PIPE_REG_SKID_EN
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic                r_in_ready;
   logic                w_ld_main_skid;
   logic                w_ld_skid;
   logic                w_clr_skid_ctrl;
`endif

   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = r_main_data;
   assign out_ctrl  = r_main_ctrl;
   assign stall_cnt = r_stall_cnt;

`ifdef STAGE_PIPE_REG_SKID_EN
   assign in_ready = r_in_ready;
`else
   assign in_ready = !out_valid | out_ready;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_fire   = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ld_main_in    = 1'b0;
      w_clr_main_ctrl = 1'b0;
`ifdef STAGE_PIPE_REG_SKID_EN
      w_ld_main_skid  = 1'b0;
      w_ld_skid       = 1'b0;
      w_clr_skid_ctrl = 1'b0;
`endif
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt  = ST_BUSY;
               w_ld_main_in = 1'b1;
            end
         end
         ST_BUSY: begin
            if (w_accept && w_fire) begin
               w_ld_main_in = 1'b1;
`ifdef STAGE_PIPE_REG_SKID_EN
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_ld_skid   = 1'b1;
`endif
            end else if (w_fire) begin
               w_state_nxt     = ST_EMPTY;
               w_clr_main_ctrl = 1'b1;
            end
         end
`ifdef STAGE_PIPE_REG_SKID_EN
         ST_FULL: begin
            if (w_fire) begin
               w_state_nxt    = ST_BUSY;
               w_ld_main_skid = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt     = ST_EMPTY;
            w_clr_main_ctrl = 1'b1;
         end
      endcase
      // Flush overrides every load; a same-cycle fire has already been delivered.
      if (flush) begin
         w_state_nxt     = ST_EMPTY;
         w_ld_main_in    = 1'b0;
         w_clr_main_ctrl = 1'b1;
`ifdef STAGE_PIPE_REG_SKID_EN
         w_ld_main_skid  = 1'b0;
         w_ld_skid       = 1'b0;
         w_clr_skid_ctrl = 1'b1;
`endif
      end
   end

   // Payload keeps its last value when the stage drains; only ctrl is zeroed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
      end else if (w_clr_main_ctrl) begin
         r_main_ctrl <= '0;
      end else if (w_ld_main_in) begin
         r_main_data <= in_data;
         r_main_ctrl <= in_ctrl;
`ifdef STAGE_PIPE_REG_SKID_EN
      end else if (w_ld_main_skid) begin
         r_main_data <= r_skid_data;
         r_main_ctrl <= r_skid_ctrl;
`endif
      end
   end

`ifdef STAGE_PIPE_REG_SKID_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_in_ready  <= 1'b1;
      end else begin
         r_in_ready <= (w_state_nxt != ST_FULL);
         if (w_clr_skid_ctrl) begin
            r_skid_ctrl <= '0;
         end else if (w_ld_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != C_CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
//  tb_stage_pipe_reg
//  Scoreboard bench for stage_pipe_reg (CNT_W=4); covers both builds.
//  Revision: 1.0
// ============================================================================
module tb_stage_pipe_reg;

   localparam int DATA_W = 64;
   localparam int CTRL_W = 25;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              cnt_clr;
   logic [CNT_W-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W+CTRL_W-1:0] q[$];
   logic [CNT_W-1:0]         m_cnt = '0;

   stage_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .cnt_clr   (cnt_clr),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
      return d[CTRL_W-1:0] ^ 25'h1ABCDE5;
   endfunction

   task automatic set_beat(input logic v, input logic [DATA_W-1:0] d);
      in_valid = v;
      in_data  = d;
      in_ctrl  = ctrl_of(d);
   endtask

   // Checks outputs against the model mid-cycle, then advances the model on the edge.
   task automatic cycle(output bit acc);
      bit rdy;
      bit fir;
      int sz;
      @(negedge clk);
      sz = q.size();
      chk("out_valid", out_valid, sz != 0);
      if (sz != 0) begin
         chk("out_data", out_data, q[0][DATA_W-1:0]);
         chk("out_ctrl", out_ctrl, q[0][DATA_W +: CTRL_W]);
      end else begin
         chk("out_ctrl_bubble", out_ctrl, 0);
      end
`ifdef STAGE_PIPE_REG_SKID_EN
      rdy = (sz < 2);
`else
      rdy = (sz == 0) || out_ready;
`endif
      chk("in_ready", in_ready, rdy);
      chk("stall_cnt", stall_cnt, m_cnt);
      acc = in_valid && rdy && rst;
      fir = (sz != 0) && out_ready;
      @(posedge clk);
      if (!rst) begin
         q.delete();
         m_cnt = '0;
         acc   = 1'b0;
      end else begin
         if (cnt_clr) m_cnt = '0;
         else if (sz != 0 && !out_ready && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
         if (fir) void'(q.pop_front());
         if (flush) begin
            q.delete();
            acc = 1'b0;
         end else if (acc) begin
            q.push_back({in_ctrl, in_data});
         end
      end
      #1;
   endtask

   // Sends n beats base..base+n-1 holding each until accepted; out_ready low for hold cycles.
   task automatic stream(input int n, input logic [DATA_W-1:0] base, input int hold);
      int idx = 0;
      int cyc = 0;
      bit acc;
      while ((idx < n || q.size() != 0) && cyc < 200) begin
         out_ready = (cyc >= hold);
         set_beat(idx < n, base + DATA_W'(idx));
         cycle(acc);
         if (acc) idx++;
         cyc++;
      end
      set_beat(1'b0, '0);
      chk("stream_done", (idx == n) && (q.size() == 0), 1);
   endtask

   initial begin
      bit acc;
      rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      set_beat(1'b0, '0);
      #1;
      cycle(acc);
      cycle(acc);
      chk("reset_out_data", out_data, 0);
      rst = 1'b1;

      // streaming
      stream(3, 64'd1, 0);
      cycle(acc);

      // back-pressure with four stalled cycles
      stream(3, 64'hA, 4);
      cycle(acc);

      // flush with a full stage and a simultaneous incoming beat
      out_ready = 1'b0;
      set_beat(1'b1, 64'h11); cycle(acc);
      set_beat(1'b1, 64'h22); cycle(acc);
      set_beat(1'b1, 64'hDEAD); flush = 1'b1; cycle(acc);
      flush = 1'b0; set_beat(1'b0, '0);
      cycle(acc);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      stream(1, 64'h55, 0);

      // stall counter saturation and clear
      cnt_clr = 1'b1; cycle(acc); cnt_clr = 1'b0;
      out_ready = 1'b0;
      set_beat(1'b1, 64'h77); cycle(acc);
      set_beat(1'b0, '0);
      for (int i = 0; i < 20; i++) cycle(acc);
      chk("stall_sat", stall_cnt, 15);
      cnt_clr = 1'b1; cycle(acc);
      cnt_clr = 1'b0; cycle(acc);
      chk("stall_after_clr", stall_cnt, 1);
      out_ready = 1'b1;
      cycle(acc);
      cnt_clr = 1'b1; cycle(acc); cnt_clr = 1'b0;

      // random valid/ready/flush traffic
      begin
         logic [DATA_W-1:0] d = 64'h1000;
         set_beat(1'b0, d);
         for (int i = 0; i < 100; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            if (!in_valid) set_beat(1'($urandom_range(0, 1)), d);
            cycle(acc);
            if (acc || flush) begin
               d = d + 64'd1;
               set_beat(1'($urandom_range(0, 1)), d);
            end
         end
         flush = 1'b0; cnt_clr = 1'b0;
         set_beat(1'b0, '0);
         stream(0, '0, 0);
      end

      // asynchronous reset between clock edges with beats held
      out_ready = 1'b0;
      set_beat(1'b1, 64'h31); cycle(acc);
      set_beat(1'b1, 64'h32); cycle(acc);
      set_beat(1'b0, '0);
      cycle(acc);
      #3;
      rst = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_stall_cnt", stall_cnt, 0);
      chk("async_out_ctrl", out_ctrl, 0);
      chk("async_out_data", out_data, 0);
      chk("async_in_ready", in_ready, 1);
      q.delete();
      m_cnt = '0;
      out_ready = 1'b1;
      cycle(acc);
      rst = 1'b1;
      stream(2, 64'h100, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
